alu_multicycle: RTL
===================

# alu_multicycle

Handshaked multi-cycle ALU responder: it accepts one operation at a time over a valid/ready request channel and returns a registered 32-bit result with a zero flag over a valid/ready response channel. Single-cycle operations complete in 1 cycle; shifts iterate one bit per cycle and multiply runs as 32-step shift-add. It sits between the issuing datapath or bench and the result consumer. It uses the same 4-bit control encoding and `out`/`zero` result semantics as the combinational `alu`.

## Interface
- WIDTH, 32: operand and result width; only 32 is supported.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  request present on left/right/control.
- req_ready  out  1  block can accept; high only in IDLE.
- left  in  32  operand A.
- right  in  32  operand B; for shifts, right[4:0] is the shift amount.
- control  in  4  operation code.
- rsp_valid  out  1  out/zero hold a valid result.
- rsp_ready  in  1  consumer takes the result.
- out  out  32  registered result.
- zero  out  1  registered, equals (out == 0) for the held result.

## Operation
- Control codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR: single-cycle.
  - 1000 SLL, 1001 SRL, 1010 SRA: iterative, shift amount = right[4:0].
  - 1011 MUL: iterative, low 32 bits of the product.
- Any other code: result 0, zero = 1, latency 1.
- Arithmetic: ADD/SUB wrap modulo 2^32 with no carry/overflow output. SLT gives 32'h1 or 32'h0. SRA replicates bit 31. MUL is unsigned shift-add over 32 steps and is sign-agnostic for the low 32 bits.
- FSM states:
  - IDLE: req_ready = 1. On accept, latch the operands and control.
    - Single-cycle op, or shift with amount 0: go to DONE.
    - Shift with amount > 0: go to EXEC with counter = amount.
    - MUL: go to EXEC with counter = 32.
  - EXEC: each cycle performs one shift step, or one multiply add-and-shift, and decrements the counter. When the counter reaches 0, write out/zero and go to DONE.
  - DONE: rsp_valid = 1, out/zero stable. When rsp_valid && rsp_ready, go to IDLE.
- Requests are not accepted outside IDLE. left/right/control are ignored once latched.
- Reset, including mid-EXEC or mid-DONE, aborts the operation immediately. The pending result is discarded.

## Timing
- Reset values: req_ready = 1, rsp_valid = 0, out = 0, zero = 0, state = IDLE, counter = 0.
- Accept at edge k (req_valid && req_ready). rsp_valid then rises at edge:
  - k+1 for single-cycle ops, shift amount 0, and illegal codes;
  - k+1+n for shifts by n;
  - k+33 for MUL.
- Response taken at edge m (rsp_valid && rsp_ready): rsp_valid = 0 and req_ready = 1 after m. The earliest next accept is edge m+1, so there is no same-edge response-and-accept.
- rsp_ready held low keeps DONE indefinitely with out/zero unchanged.
- rsp_ready is ignored outside DONE. req_valid is ignored outside IDLE.
- Maximum throughput is one single-cycle op per 2 cycles.

## Structure
- Package alu_pkg holds:
  - localparams for all 4-bit control codes;
  - the FSM state encoding (IDLE, EXEC, DONE);
  - WIDTH and SHAMT_W = 5 constants.
- Sub-module alu_iter_dp holds the iterative datapath: shift register, multiplicand/multiplier/accumulator registers, step counter, and `done` strobe. The top level holds the FSM, handshake, single-cycle ops, and result register.

## Test plan
- Reset mid-operation: start MUL 7 * 9, pull rst_n low at cycle 10 -> outputs return to reset values asynchronously; after release, req_ready = 1 and no response is produced.
- Single-cycle ops: ADD 0 + 0 -> out = 0, zero = 1, rsp_valid one cycle after accept. SUB 5 - 7 -> 32'hFFFF_FFFE, zero = 0. SLT -1 < 1 -> 32'h1. ADD 32'hFFFF_FFFF + 1 -> 0, zero = 1.
- Shifts:
  - SRA 32'h8000_0000 by 4 -> 32'hF800_0000 at accept+5.
  - SRL same operands -> 32'h0800_0000.
  - SLL 1 by 31 -> 32'h8000_0000 at accept+32.
  - SLL by 0 -> left unchanged at accept+1.
- MUL: 32'h0001_0000 * 32'h0001_0000 -> 0, zero = 1 at accept+33. 123 * 456 -> 56088.
- Backpressure: hold rsp_ready = 0 for 10 cycles with req_valid high and new operands changing -> out stable, req_ready = 0, the second request is accepted only at the edge after the response handshake.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the multi-cycle ALU: widths, control codes and FSM states.
// The control codes match the combinational alu.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int CNT_W   = 6;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iter(input logic [3:0] ctl);
    return (ctl == OP_SLL) || (ctl == OP_SRL) || (ctl == OP_SRA) || (ctl == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_iter_dp.sv
// Iterative datapath: one-bit-per-cycle shifter and 32-step shift-add multiplier.
// done is high whenever the step counter is zero, so non-iterative ops report done immediately.
module alu_iter_dp
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  logic [3:0]       op_q;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  // A start loads all registers; the counter only runs for shifts and multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      shreg  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      op_q   <= control;
      shreg  <= left;
      mcand  <= left;
      mplier <= right;
      acc    <= '0;
      if (control == OP_MUL)
        cnt <= 6'd32;
      else if (is_iter(control))
        cnt <= {1'b0, right[SHAMT_W-1:0]};
      else
        cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 6'd1;
      case (op_q)
        OP_SLL: shreg <= shreg << 1;
        OP_SRL: shreg <= shreg >> 1;
        OP_SRA: shreg <= {shreg[WIDTH-1], shreg[WIDTH-1:1]};
        OP_MUL: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
        default: ;
      endcase
    end
  end

  assign result = (op_q == OP_MUL) ? acc : shreg;
  assign done   = (cnt == '0);

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle ALU: FSM, operand latch, single-cycle ops and result register.
// Every operation passes through EXEC, so out/zero are written one edge after the step counter empties.
module alu_multicycle
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic [3:0]       control,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  state_t           state, next_state;
  logic [WIDTH-1:0] left_q, right_q;
  logic [3:0]       ctl_q;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] dp_result;
  logic             dp_done;
  logic             accept;
  logic             slt;

  assign accept = req_valid && req_ready;

  alu_iter_dp u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .control (control),
    .left    (left),
    .right   (right),
    .result  (dp_result),
    .done    (dp_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          next_state = EXEC;
      end
      EXEC: begin
        if (dp_done)
          next_state = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q  <= '0;
      right_q <= '0;
      ctl_q   <= '0;
    end else if (accept) begin
      left_q  <= left;
      right_q <= right;
      ctl_q   <= control;
    end
  end

  // Illegal codes fall through to zero.
  always_comb begin
    slt     = $signed(left_q) < $signed(right_q);
    alu_res = '0;
    case (ctl_q)
      OP_AND: alu_res = left_q & right_q;
      OP_OR:  alu_res = left_q | right_q;
      OP_ADD: alu_res = left_q + right_q;
      OP_SUB: alu_res = left_q - right_q;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR: alu_res = ~(left_q | right_q);
      OP_SLL, OP_SRL, OP_SRA, OP_MUL: alu_res = dp_result;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      zero <= 1'b0;
    end else if (state == EXEC && dp_done) begin
      out  <= alu_res;
      zero <= (alu_res == '0);
    end
  end

endmodule
